// File: rtl/div_ratio_meter.sv
// Measures the rise-to-rise period and rise-to-fall high time of a divided
// clock sampled as data in the clk_ref domain, with lock and overflow status.
module div_ratio_meter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             meas_en,
  input  logic             clk_in,
  output logic [WIDTH-1:0] ratio,
  output logic [WIDTH-1:0] high_time,
  output logic             ratio_valid,
  output logic             locked,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT
  } state_t;

  state_t           state, state_nx;
  logic             clk_in_d;
  logic             rise, fall;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] high_sh, high_sh_nx;
  logic [WIDTH-1:0] ratio_nx, high_time_nx;
  logic             valid_nx, locked_nx, overflow_nx;
  logic             have_prev, have_prev_nx;

  assign rise = clk_in & ~clk_in_d;
  assign fall = ~clk_in & clk_in_d;

  // State and datapath registers
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      clk_in_d    <= 1'b0;
      cnt         <= '0;
      high_sh     <= '0;
      ratio       <= '0;
      high_time   <= '0;
      ratio_valid <= 1'b0;
      locked      <= 1'b0;
      overflow    <= 1'b0;
      have_prev   <= 1'b0;
    end else begin
      state       <= state_nx;
      clk_in_d    <= clk_in;
      cnt         <= cnt_nx;
      high_sh     <= high_sh_nx;
      ratio       <= ratio_nx;
      high_time   <= high_time_nx;
      ratio_valid <= valid_nx;
      locked      <= locked_nx;
      overflow    <= overflow_nx;
      have_prev   <= have_prev_nx;
    end
  end

  // Next-state and next-output logic; meas_en low overrides any edge
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    high_sh_nx   = high_sh;
    ratio_nx     = ratio;
    high_time_nx = high_time;
    valid_nx     = 1'b0;
    locked_nx    = locked;
    overflow_nx  = overflow;
    have_prev_nx = have_prev;

    if (!meas_en) begin
      state_nx     = IDLE;
      cnt_nx       = '0;
      locked_nx    = 1'b0;
      overflow_nx  = 1'b0;
      have_prev_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nx     = ARM;
          have_prev_nx = 1'b0;
        end
        ARM: begin
          have_prev_nx = 1'b0;
          if (rise) begin
            state_nx = COUNT;
            cnt_nx   = CNT_ONE;
          end
        end
        COUNT: begin
          if (fall) high_sh_nx = cnt;
          if (rise) begin
            // ratio still holds the previous valid measurement here
            ratio_nx     = cnt;
            high_time_nx = high_sh;
            valid_nx     = 1'b1;
            locked_nx    = have_prev && (cnt == ratio);
            have_prev_nx = 1'b1;
            cnt_nx       = CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            state_nx     = ARM;
            overflow_nx  = 1'b1;
            locked_nx    = 1'b0;
            have_prev_nx = 1'b0;
            cnt_nx       = '0;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ratio_meter.sv
// Directed self-checking bench for div_ratio_meter (WIDTH=3).
module tb_div_ratio_meter;

  localparam int unsigned WIDTH = 3;

  logic             clk_ref;
  logic             rst;
  logic             meas_en;
  logic             clk_in;
  logic [WIDTH-1:0] ratio;
  logic [WIDTH-1:0] high_time;
  logic             ratio_valid;
  logic             locked;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  // Snapshot of the most recent ratio_valid pulse
  int   pulses   = 0;
  int   p_ratio  = 0;
  int   p_high   = 0;
  logic p_locked = 1'b0;

  div_ratio_meter #(.WIDTH(WIDTH)) dut (
    .clk_ref     (clk_ref),
    .rst         (rst),
    .meas_en     (meas_en),
    .clk_in      (clk_in),
    .ratio       (ratio),
    .high_time   (high_time),
    .ratio_valid (ratio_valid),
    .locked      (locked),
    .overflow    (overflow)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample outputs on the falling edge, then drive the next clk_in value
  task automatic tick(input logic v);
    @(negedge clk_ref);
    if (ratio_valid === 1'b1) begin
      pulses++;
      p_ratio  = int'(ratio);
      p_high   = int'(high_time);
      p_locked = locked;
    end
    clk_in = v;
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) tick(1'b1);
      for (int i = 0; i < lo; i++) tick(1'b0);
    end
  endtask

  task automatic restart();
    meas_en = 1'b0;
    tick(1'b0);
    tick(1'b0);
    meas_en = 1'b1;
    tick(1'b0);
    tick(1'b0);
    pulses = 0;
  endtask

  initial begin
    rst     = 1'b1;
    meas_en = 1'b0;
    clk_in  = 1'b0;
    #7;
    check("rst_ratio", 32'(ratio), 0);
    check("rst_high", 32'(high_time), 0);
    check("rst_valid", 32'(ratio_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;

    // 3 high / 3 low
    restart();
    wave(3, 3, 2);
    check("p6_first_cnt", 32'(pulses), 1);
    check("p6_first_ratio", 32'(p_ratio), 6);
    check("p6_first_high", 32'(p_high), 3);
    check("p6_first_lock", 32'(p_locked), 0);
    wave(3, 3, 2);
    check("p6_cnt", 32'(pulses), 3);
    check("p6_ratio", 32'(p_ratio), 6);
    check("p6_lock", 32'(p_locked), 1);

    // 2 high / 3 low
    restart();
    wave(2, 3, 2);
    check("p5_first_ratio", 32'(p_ratio), 5);
    check("p5_first_high", 32'(p_high), 2);
    check("p5_first_lock", 32'(p_locked), 0);
    wave(2, 3, 1);
    check("p5_cnt", 32'(pulses), 2);
    check("p5_lock", 32'(p_locked), 1);

    // Period change 6 -> 4
    restart();
    wave(3, 3, 3);
    check("chg_pre_lock", 32'(p_locked), 1);
    wave(2, 2, 2);
    check("chg_cnt", 32'(pulses), 4);
    check("chg_ratio", 32'(p_ratio), 4);
    check("chg_high", 32'(p_high), 2);
    check("chg_lock_drop", 32'(p_locked), 0);
    wave(2, 2, 1);
    check("chg_cnt2", 32'(pulses), 5);
    check("chg_lock_back", 32'(p_locked), 1);

    // Boundaries: maximum ratio 7, minimum ratio 2
    restart();
    wave(3, 4, 3);
    check("max_ratio", 32'(p_ratio), 7);
    check("max_high", 32'(p_high), 3);
    check("max_lock", 32'(p_locked), 1);
    check("max_ovf", 32'(overflow), 0);
    restart();
    wave(1, 1, 3);
    check("min_cnt", 32'(pulses), 2);
    check("min_ratio", 32'(p_ratio), 2);
    check("min_high", 32'(p_high), 1);
    check("min_lock", 32'(p_locked), 1);

    // Overflow: locked run, one more rise, then clk_in held low
    restart();
    wave(3, 3, 3);
    tick(1'b1);
    for (int i = 0; i < 7; i++) tick(1'b0);
    check("ovf_pre_flag", 32'(overflow), 0);
    check("ovf_pre_lock", 32'(locked), 1);
    tick(1'b0);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_lock", 32'(locked), 0);
    for (int i = 0; i < 5; i++) tick(1'b0);
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_no_pulse", 32'(pulses), 3);
    meas_en = 1'b0;
    tick(1'b0);
    check("ovf_clear", 32'(overflow), 0);
    check("ovf_hold_ratio", 32'(ratio), 6);
    check("ovf_hold_high", 32'(high_time), 3);

    // Reset mid-period
    restart();
    wave(3, 3, 2);
    tick(1'b1);
    tick(1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_ratio", 32'(ratio), 0);
    check("mid_rst_high", 32'(high_time), 0);
    check("mid_rst_valid", 32'(ratio_valid), 0);
    check("mid_rst_lock", 32'(locked), 0);
    pulses = 0;
    tick(1'b0);
    tick(1'b0);
    #2;
    rst = 1'b0;
    check("mid_rst_nopulse", 32'(pulses), 0);
    tick(1'b0);
    tick(1'b0);
    wave(3, 3, 2);
    check("post_rst_cnt", 32'(pulses), 1);
    check("post_rst_ratio", 32'(p_ratio), 6);

    // meas_en dropped during a locked run
    restart();
    wave(3, 3, 3);
    check("dis_pre_lock", 32'(p_locked), 1);
    meas_en = 1'b0;
    wave(2, 2, 3);
    check("dis_nopulse", 32'(pulses), 2);
    check("dis_hold_ratio", 32'(ratio), 6);
    check("dis_hold_high", 32'(high_time), 3);
    check("dis_lock", 32'(locked), 0);
    meas_en = 1'b1;
    wave(2, 2, 1);
    check("en_one_rise", 32'(pulses), 2);
    wave(2, 2, 1);
    check("en_two_rise", 32'(pulses), 3);
    check("en_ratio", 32'(p_ratio), 4);
    check("en_lock", 32'(p_locked), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ratio_meter.md
DIV_RATIO_METER -- requirements
Module: div_ratio_meter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the width of the measured ratio and high-time fields.
REQ-002 The block SHALL have port clk_ref, input, 1 bit: the single block clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port meas_en, input, 1 bit: measurement enable, level-sensitive.
REQ-005 The block SHALL have port clk_in, input, 1 bit: the divided clock under test, synchronous to clk_ref and sampled as data.
REQ-006 The block SHALL have port ratio, output, WIDTH bits: last measured rise-to-rise period in clk_ref cycles.
REQ-007 The block SHALL have port high_time, output, WIDTH bits: last measured rise-to-fall time in clk_ref cycles.
REQ-008 The block SHALL have port ratio_valid, output, 1 bit: one-cycle pulse marking an update of ratio/high_time.
REQ-009 The block SHALL have port locked, output, 1 bit: two consecutive equal ratio measurements have been seen.
REQ-010 The block SHALL have port overflow, output, 1 bit: sticky flag set when the period exceeds the counter range.

Function
REQ-011 The block SHALL register clk_in into clk_in_d each cycle: rise = clk_in & ~clk_in_d; fall = ~clk_in & clk_in_d.
REQ-012 The FSM SHALL have states IDLE, ARM and COUNT.
REQ-013 Transitions SHALL be: IDLE->ARM when meas_en=1; ARM->COUNT on rise; COUNT->COUNT on rise (valid measurement); COUNT->ARM on counter saturation; any state->IDLE when meas_en=0.
REQ-014 On entry to COUNT, and on every rise while in COUNT, the counter cnt SHALL load 1; on every other COUNT cycle it SHALL increment by 1.
REQ-015 On rise in COUNT, ratio SHALL load cnt, and ratio_valid SHALL be 1 for exactly the following cycle; an edge N clk_ref cycles after the previous one yields ratio=N.
REQ-016 On fall in COUNT, high_time SHALL capture cnt into a shadow register; that value SHALL be copied to high_time on the same edge that updates ratio.
REQ-017 The minimum measurable ratio SHALL be 2; the maximum SHALL be 2^WIDTH-1.
REQ-018 If cnt=2^WIDTH-1 in COUNT and no rise occurs, the block SHALL set overflow=1 and clear locked; FSM->ARM with no ratio_valid pulse.
REQ-019 overflow SHALL stay set until rst or meas_en=0.
REQ-020 locked SHALL be set on a valid measurement equal to the previous valid measurement.
REQ-021 locked SHALL be cleared on a valid measurement that differs from the previous one, on overflow, and on meas_en=0.
REQ-022 The first valid measurement after ARM SHALL NOT set locked.
REQ-023 With meas_en=0, ratio and high_time SHALL hold their last values; ratio_valid, locked and overflow SHALL be 0 from the next cycle.
REQ-024 A rise and meas_en falling in the same cycle SHALL give priority to meas_en: no update occurs.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 When rst=1, the block SHALL asynchronously force: FSM=IDLE, cnt=0, clk_in_d=0, ratio=0, high_time=0, ratio_valid=0, locked=0, overflow=0.
REQ-027 After rst is released, the block SHALL resume from IDLE on the first clk_ref rising edge.
REQ-028 When rst is asserted mid-measurement, the partial count SHALL be discarded and no ratio_valid pulse SHALL be issued.

Verification
REQ-029 clk_in driven high 3 / low 3 cycles, meas_en=1 -> ratio=6 and high_time=3 with one ratio_valid pulse per 6 cycles; locked=1 after the second pulse.
REQ-030 clk_in driven high 2 / low 3 cycles -> ratio=5, high_time=2, locked=1 after the second pulse.
REQ-031 Period changed from 6 to 4 mid-run -> first ratio=4 pulse has locked=0; the next pulse restores locked=1.
REQ-032 clk_in held low after one rise (WIDTH=3) -> overflow=1 after 7 cycles in COUNT, no ratio_valid, locked=0; then meas_en=0 -> overflow=0 next cycle.
REQ-033 rst asserted mid-period -> all outputs 0 immediately; after release and 2 clk_in rises, ratio_valid resumes with the correct ratio.
REQ-034 meas_en dropped during a locked run -> ratio and high_time hold, locked=0, no further pulses until meas_en=1 and 2 rises have occurred.
